// File: rtl/seq_divider_64_if.sv
// Handshake and operand/result bundle between the execute stage and seq_divider_64.
// The master requests divisions and the slave (the divider) returns results.
interface seq_divider_64_if;
  logic        start;
  logic        is_signed;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        ready;
  logic        busy;
  logic        done;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  modport master (
    output start, is_signed, dividend, divisor,
    input  ready, busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output ready, busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider_64.sv
// Multi-cycle 64-bit restoring divider, one quotient bit per cycle, signed or unsigned,
// with a shared subtractor_64 doing the trial subtraction each iteration.

module subtractor_64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] diff,
  output logic        carry_out
);
  // carry_out = 1 means no borrow, i.e. a >= b unsigned
  assign {carry_out, diff} = {1'b0, a} + {1'b0, ~b} + 65'd1;
endmodule

// state | meaning
// IDLE  | ready for a new request, results held
// RUN   | 64 restoring iterations, one quotient bit per edge
// FIX   | apply result signs and overflow flag
// DONE  | one-cycle done pulse
module seq_divider_64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  seq_divider_64_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_nxt;
  logic [5:0]       cnt;
  logic [WIDTH-1:0] dvd_sh, dsr_mag, q_acc, r_acc, quo, rem;
  logic             neg_q, neg_r, ovf_pend, dbz, ovf;
  logic             ready, busy, done;
  logic [WIDTH-1:0] dvd_mag, dsr_in_mag, trial_a, sub_diff;
  logic             sub_carry, trial_ok, divisor_zero;

  assign dvd_mag      = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
  assign dsr_in_mag   = (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
  assign divisor_zero = (bus.divisor == '0);

  // S = {R, next dividend bit}; its bit 64 is r_acc[63], the low 64 bits go to the subtractor
  assign trial_a  = {r_acc[WIDTH-2:0], dvd_sh[WIDTH-1]};
  assign trial_ok = r_acc[WIDTH-1] | sub_carry;

  subtractor_64 u_sub (
    .a         (trial_a),
    .b         (dsr_mag),
    .diff      (sub_diff),
    .carry_out (sub_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.start) state_nxt = divisor_zero ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == 6'd63) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      dvd_sh   <= '0;
      dsr_mag  <= '0;
      q_acc    <= '0;
      r_acc    <= '0;
      quo      <= '0;
      rem      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      ovf_pend <= 1'b0;
      dbz      <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            neg_q    <= (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]) & bus.is_signed;
            neg_r    <= bus.dividend[WIDTH-1] & bus.is_signed;
            ovf_pend <= bus.is_signed && (bus.dividend == MIN_NEG) && (bus.divisor == '1);
            dvd_sh   <= dvd_mag;
            dsr_mag  <= dsr_in_mag;
            q_acc    <= '0;
            r_acc    <= '0;
            cnt      <= '0;
            dbz      <= 1'b0;
            ovf      <= 1'b0;
            if (divisor_zero) begin
              quo <= '1;
              rem <= bus.dividend;
              dbz <= 1'b1;
            end
          end
        end
        RUN: begin
          r_acc  <= trial_ok ? sub_diff : trial_a;
          q_acc  <= {q_acc[WIDTH-2:0], trial_ok};
          dvd_sh <= {dvd_sh[WIDTH-2:0], 1'b0};
          cnt    <= cnt + 6'd1;
        end
        FIX: begin
          // MIN / -1 needs no special case: the magnitude path already yields MIN, 0
          quo <= neg_q ? -q_acc : q_acc;
          rem <= neg_r ? -r_acc : r_acc;
          ovf <= ovf_pend;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready       = ready;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.quotient    = quo;
  assign bus.remainder   = rem;
  assign bus.div_by_zero = dbz;
  assign bus.overflow    = ovf;
endmodule
